// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the input debouncer.
// Tick rate and prescaler sizing live here.
package input_debouncer_pkg;

  localparam int TICK_HZ = 1000;

  function automatic int tick_cycles(input int clk_hz);
    int n;
    n = clk_hz / TICK_HZ;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced input: 2-flop sync, stability counter,
// debounced level and registered edge pulses.
module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  input  logic tick,
  output logic state,
  output logic rise,
  output logic fall,
  output logic flip
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [1:0]    sync_q;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          state_q;

  assign sync = sync_q[1];
  // High on the cycle the edge pulses are being registered
  assign flip = state ^ state_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q  <= '0;
      cnt     <= '0;
      state   <= 1'b0;
      state_q <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state;
      rise    <= state & ~state_q;
      fall    <= ~state & state_q;
      if (sync == state) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(STABLE_TICKS - 1)) begin
          state <= sync;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for board switches/buttons: shared 1 ms
// prescaler, per-bit debounce, sticky flags and irq.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH        = 21,
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_raw,
  input  logic [WIDTH-1:0] i_clr,
  output logic [WIDTH-1:0] o_state,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_event,
  output logic             o_irq
);

  localparam int TC = tick_cycles(CLK_FREQ_HZ);
  localparam int PW = (TC > 1) ? $clog2(TC) : 1;

  logic [PW-1:0]    pcnt;
  logic             tick;
  logic [WIDTH-1:0] flip;

  assign tick = (pcnt == PW'(TC - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk  (clk),
      .rstn (rstn),
      .raw  (i_raw[i]),
      .tick (tick),
      .state(o_state[i]),
      .rise (o_rise[i]),
      .fall (o_fall[i]),
      .flip (flip[i])
    );
  end

  // A new edge beats a clear arriving on the same cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_event <= '0;
      o_irq   <= 1'b0;
    end else begin
      o_event <= flip | (o_event & ~i_clr);
      o_irq   <= |o_event;
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: expected edges
// are queued at stimulus time and matched on each pulse.
module tb_input_debouncer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] i_raw = '0;
  logic [W-1:0] i_clr = '0;
  logic [W-1:0] o_state;
  logic [W-1:0] o_rise;
  logic [W-1:0] o_fall;
  logic [W-1:0] o_event;
  logic         o_irq;

  input_debouncer #(
    .WIDTH       (W),
    .CLK_FREQ_HZ (10_000),
    .STABLE_TICKS(3)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .i_raw  (i_raw),
    .i_clr  (i_clr),
    .o_state(o_state),
    .o_rise (o_rise),
    .o_fall (o_fall),
    .o_event(o_event),
    .o_irq  (o_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int           t0;
  } exp_t;

  exp_t         sb[$];
  int           nvec = 0;
  int           nerr = 0;
  int           cyc = 0;
  int           rbase = 0;
  bit           pend = 1'b0;
  logic [W-1:0] prev_ev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, want);
    end
  endtask

  // Each pulse cycle must match the oldest queued edge
  always @(negedge clk) begin : mon
    logic [W-1:0] m;
    exp_t         e;
    int           d;
    m = o_rise | o_fall;
    if (m != '0) begin
      if (sb.size() == 0) begin
        chk("spurious", 32'({o_rise, o_fall}), 0);
      end else begin
        e = sb.pop_front();
        d = cyc - e.t0;
        chk("rise", 32'(o_rise), 32'(e.rise));
        chk("fall", 32'(o_fall), 32'(e.fall));
        chk("lat_lo", 32'(d >= 24), 1);
        chk("lat_hi", 32'(d <= 33), 1);
        chk("event", 32'(o_event & m), 32'(m));
        chk("state", 32'(o_state & m), 32'(e.rise));
      end
      if (prev_ev == '0) chk("irq_lag", 32'(o_irq), 0);
      pend = 1'b1;
    end else if (pend) begin
      chk("irq_set", 32'(o_irq), 1);
      pend = 1'b0;
    end
    prev_ev = o_event;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_edge(input logic [W-1:0] r,
                             input logic [W-1:0] f);
    exp_t e;
    e.rise = r;
    e.fall = f;
    e.t0   = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
    step(2);
  endtask

  task automatic clr_all();
    i_clr = '1;
    step(1);
    i_clr = '0;
    chk("clr_event", 32'(o_event), 0);
    chk("irq_hold", 32'(o_irq), 1);
    step(1);
    chk("irq_drop", 32'(o_irq), 0);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) begin
      step(1);
      chk("reset_out",
          32'({o_state, o_rise, o_fall, o_event, o_irq}), 0);
    end
    rstn  = 1'b1;
    rbase = cyc;
  endtask

  initial begin
    int k;
    step(1);
    do_reset(4);
    step(1);
    chk("idle_state", 32'(o_state), 0);
    chk("idle_irq", 32'(o_irq), 0);

    i_raw[0] = 1'b1;
    expect_edge(4'b0001, 4'b0000);
    wait_sb(60);
    clr_all();

    for (int t = 0; t < 14; t++) begin
      i_raw[1] = ~i_raw[1];
      step(7);
    end
    chk("bounce_state", 32'(o_state[1]), 0);
    i_raw[1] = 1'b1;
    expect_edge(4'b0010, 4'b0000);
    wait_sb(60);
    clr_all();

    i_raw[2] = 1'b1;
    expect_edge(4'b0100, 4'b0000);
    k = 0;
    while (!o_state[2] && k < 60) begin
      step(1);
      k++;
    end
    chk("b2_seen", 32'(o_state[2]), 1);
    i_clr = 4'b0100;
    step(1);
    i_clr = '0;
    chk("set_wins", 32'(o_event[2]), 1);
    wait_sb(5);
    clr_all();

    i_raw[0] = 1'b0;
    i_raw[3] = 1'b1;
    expect_edge(4'b1000, 4'b0001);
    wait_sb(60);
    clr_all();
    i_raw[0] = 1'b1;
    i_raw[3] = 1'b0;
    expect_edge(4'b0001, 4'b1000);
    wait_sb(60);
    clr_all();

    i_raw[0] = 1'b0;
    expect_edge(4'b0000, 4'b0001);
    wait_sb(60);
    clr_all();
    // Drive just after a tick so the flip would land late
    k = 0;
    while (((cyc - rbase) % 10) != 8 && k < 20) begin
      step(1);
      k++;
    end
    i_raw[0] = 1'b1;
    step(25);
    chk("mid_state", 32'(o_state[0]), 0);
    do_reset(2);
    expect_edge(4'b0111, 4'b0000);
    wait_sb(60);
    clr_all();

    i_raw = 4'hF;
    do_reset(3);
    expect_edge(4'b1111, 4'b0000);
    wait_sb(60);
    chk("final_state", 32'(o_state), 32'hF);
    chk("final_event", 32'(o_event), 32'hF);
    chk("final_irq", 32'(o_irq), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
